// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment code table, scan FSM states and helpers
//
// Purpose:
//   Constants and helpers shared by the 7-segment encoder and scan decoder.
//   SEG_CODE[n] is the active-high g..a pattern shown for hex nibble n.
//   It holds no ports.

package seg7_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [15:0][6:0] SEG_CODE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Callers zero-extend narrower enable vectors to 8 bits.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to hex nibble
//
// Purpose:
//   Reverse lookup of a segment pattern in SEG_CODE. An unknown pattern
//   returns nibble 0 with o_err set.
// Ports:
//   i_seg     in   7   segment pattern, bit0=a .. bit6=g
//   o_nibble  out  4   decoded hex value
//   o_err     out  1   pattern is not in the code table

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  always_comb begin
    o_nibble = 4'd0;
    o_err    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (i_seg == SEG_CODE[k]) begin
        o_nibble = 4'(k);
        o_err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment scan receiver and frame assembler
//
// Purpose:
//   Synchronises the segment lines and the one-hot digit enables.
//   Waits until the active digit's pattern has been stable for STABLE_CNT samples.
//   Decodes the pattern into the slot for that digit.
//   Publishes the whole word once every digit has been captured.
// Ports:
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous active-low reset
//   seg_in       in   7          segments, active-high, bit0=a .. bit6=g
//   dig_en       in   DIGITS     digit enables, expected one-hot
//   value        out  4*DIGITS   decoded word, digit i in [4i+3:4i]
//   value_valid  out  1          one-cycle pulse when value/digit_err update
//   digit_err    out  DIGITS     per-digit unknown-pattern flags for the frame
//   frame_err    out  1          OR of digit_err

module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_err
);

  localparam logic [7:0] CNT_FULL = 8'(STABLE_CNT);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

  // Two-flop synchronisers
  logic [6:0]          r_seg_s1, r_seg_s2;
  logic [DIGITS-1:0]   r_dig_s1, r_dig_s2;

  // Scan FSM
  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [6:0]          r_lat_seg;
  logic [DIGITS-1:0]   r_lat_dig;

  // Slot register file and frame assembly
  logic [4*DIGITS-1:0] r_slot_val;
  logic [DIGITS-1:0]   r_slot_err;
  logic [DIGITS-1:0]   r_captured;
  logic                r_frame_done;

  // Registered outputs
  logic [4*DIGITS-1:0] r_value;
  logic                r_value_valid;
  logic [DIGITS-1:0]   r_digit_err;
  logic                r_frame_err;

  logic [3:0]          w_nibble;
  logic                w_err;
  logic                w_onehot;
  logic                w_same;
  logic                w_capture;
  logic [DIGITS-1:0]   w_cap_mask;
  logic [DIGITS-1:0]   w_mask_next;
  logic [DIGITS-1:0]   w_err_next;
  logic                w_frame_last;

  seg7_pattern_decode u_decode (
    .i_seg    (r_lat_seg),
    .o_nibble (w_nibble),
    .o_err    (w_err)
  );

  assign w_onehot  = is_onehot(8'(r_dig_s2));
  assign w_same    = (r_dig_s2 == r_lat_dig) && (r_seg_s2 == r_lat_seg);
  assign w_capture = (r_state == SETTLE) && w_same && (r_cnt == CNT_LAST);
  // The latched enable is one-hot whenever the FSM is in SETTLE.
  assign w_cap_mask = w_capture ? r_lat_dig : '0;

  // The cycle that publishes a frame also clears the mask and the error bits.
  // A capture in that same cycle therefore belongs to the next frame.
  assign w_mask_next  = (r_frame_done ? '0 : r_captured) | w_cap_mask;
  assign w_err_next   = ((r_frame_done ? '0 : r_slot_err) & ~w_cap_mask)
                      | (w_cap_mask & {DIGITS{w_err}});
  assign w_frame_last = w_capture && (w_mask_next == {DIGITS{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_dig_s1 <= '0;
      r_dig_s2 <= '0;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= dig_en;
      r_dig_s2 <= r_dig_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_cnt     <= '0;
      r_lat_seg <= '0;
      r_lat_dig <= '0;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_onehot) begin
            r_lat_seg <= r_seg_s2;
            r_lat_dig <= r_dig_s2;
            r_cnt     <= 8'd1;
            r_state   <= SETTLE;
          end else begin
            r_cnt <= '0;
          end
        end
        SETTLE: begin
          if (w_same) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= CNT_FULL;
              r_state <= HOLD;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (w_onehot) begin
            r_lat_seg <= r_seg_s2;
            r_lat_dig <= r_dig_s2;
            r_cnt     <= 8'd1;
          end else begin
            r_cnt   <= '0;
            r_state <= HUNT;
          end
        end
        HOLD: begin
          if (!w_same) begin
            if (w_onehot) begin
              r_lat_seg <= r_seg_s2;
              r_lat_dig <= r_dig_s2;
              r_cnt     <= 8'd1;
              r_state   <= SETTLE;
            end else begin
              r_cnt   <= '0;
              r_state <= HUNT;
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_val   <= '0;
      r_slot_err   <= '0;
      r_captured   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (w_cap_mask[i]) begin
          r_slot_val[4*i +: 4] <= w_nibble;
        end
      end
      r_slot_err   <= w_err_next;
      r_captured   <= w_mask_next;
      r_frame_done <= w_frame_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_digit_err   <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_value_valid <= r_frame_done;
      if (r_frame_done) begin
        r_value     <= r_slot_val;
        r_digit_err <= r_slot_err;
        r_frame_err <= |r_slot_err;
      end
    end
  end

  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign digit_err   = r_digit_err;
  assign frame_err   = r_frame_err;

endmodule
